// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - out-of-order issue buffer holding ALU-bound instructions until operands arrive
// Optional RS_FAST_WAKEUP_EN lets a broadcast that clears the last dependency issue on the same edge.
module reservation_station #(
  parameter int RS_SIZE  = 8,
  parameter int RS_IDX_W = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        dispatch_en,
  input  logic [5:0]  dispatch_type,
  input  logic [31:0] dispatch_val1,
  input  logic [31:0] dispatch_val2,
  input  logic        dispatch_dep1,
  input  logic        dispatch_dep2,
  input  logic [4:0]  dispatch_tag1,
  input  logic [4:0]  dispatch_tag2,
  input  logic [31:0] dispatch_imm,
  input  logic [31:0] dispatch_pc,
  input  logic [4:0]  dispatch_rob_pos,
  output logic        rs_full,
  input  logic        alu_done,
  input  logic [31:0] alu_res,
  input  logic [4:0]  alu_rob_pos,
  input  logic        lsb_done,
  input  logic [31:0] lsb_res,
  input  logic [4:0]  lsb_rob_pos,
  output logic        alu_todo,
  output logic [5:0]  inst_type,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic [31:0] imm,
  output logic [31:0] pc,
  output logic [4:0]  out_rob_pos
);

  logic [RS_SIZE-1:0] busy;
  logic [5:0]         e_type [RS_SIZE];
  logic [31:0]        e_v1   [RS_SIZE];
  logic [31:0]        e_v2   [RS_SIZE];
  logic               e_d1   [RS_SIZE];
  logic               e_d2   [RS_SIZE];
  logic [4:0]         e_t1   [RS_SIZE];
  logic [4:0]         e_t2   [RS_SIZE];
  logic [31:0]        e_imm  [RS_SIZE];
  logic [31:0]        e_pc   [RS_SIZE];
  logic [4:0]         e_rob  [RS_SIZE];

  logic [31:0]        fwd_v1 [RS_SIZE];
  logic [31:0]        fwd_v2 [RS_SIZE];
  logic               fwd_d1 [RS_SIZE];
  logic               fwd_d2 [RS_SIZE];
  logic [RS_SIZE-1:0] ready;
  logic [RS_SIZE-1:0] busy_left;
  logic               iss_found;
  logic               free_found;
  logic [RS_IDX_W-1:0] iss_idx;
  logic [RS_IDX_W-1:0] free_idx;
  logic [31:0]        cap_v1;
  logic [31:0]        cap_v2;
  logic               cap_d1;
  logic               cap_d2;

  // Returns {still_pending, value}; the ALU broadcast wins if both happen to match.
  function automatic logic [32:0] resolve(
    input logic        dep,
    input logic [4:0]  tag,
    input logic [31:0] val,
    input logic        a_done,
    input logic [4:0]  a_tag,
    input logic [31:0] a_res,
    input logic        l_done,
    input logic [4:0]  l_tag,
    input logic [31:0] l_res
  );
    if (dep && a_done && (tag == a_tag))
      return {1'b0, a_res};
    else if (dep && l_done && (tag == l_tag))
      return {1'b0, l_res};
    else
      return {dep, val};
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      {fwd_d1[i], fwd_v1[i]} = resolve(e_d1[i], e_t1[i], e_v1[i], alu_done, alu_rob_pos, alu_res,
                                       lsb_done, lsb_rob_pos, lsb_res);
      {fwd_d2[i], fwd_v2[i]} = resolve(e_d2[i], e_t2[i], e_v2[i], alu_done, alu_rob_pos, alu_res,
                                       lsb_done, lsb_rob_pos, lsb_res);
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
`ifdef RS_FAST_WAKEUP_EN
      ready[i] = busy[i] && !fwd_d1[i] && !fwd_d2[i];
`else
      ready[i] = busy[i] && !e_d1[i] && !e_d2[i];
`endif
    end
  end

  // Lowest-index select; the free slot is searched after the issuing entry is released.
  always_comb begin
    iss_found = 1'b0;
    iss_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        iss_found = 1'b1;
        iss_idx   = RS_IDX_W'(i);
      end
    end
    busy_left = busy;
    if (iss_found)
      busy_left[iss_idx] = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_left[i]) begin
        free_found = 1'b1;
        free_idx   = RS_IDX_W'(i);
      end
    end
  end

  always_comb begin
    {cap_d1, cap_v1} = resolve(dispatch_dep1, dispatch_tag1, dispatch_val1, alu_done, alu_rob_pos,
                               alu_res, lsb_done, lsb_rob_pos, lsb_res);
    {cap_d2, cap_v2} = resolve(dispatch_dep2, dispatch_tag2, dispatch_val2, alu_done, alu_rob_pos,
                               alu_res, lsb_done, lsb_rob_pos, lsb_res);
  end

  assign rs_full = &busy;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy        <= '0;
      alu_todo    <= 1'b0;
      inst_type   <= '0;
      val1        <= '0;
      val2        <= '0;
      imm         <= '0;
      pc          <= '0;
      out_rob_pos <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        busy     <= '0;
        alu_todo <= 1'b0;
      end else begin
        alu_todo <= iss_found;
        if (iss_found) begin
          inst_type   <= e_type[iss_idx];
          val1        <= fwd_v1[iss_idx];
          val2        <= fwd_v2[iss_idx];
          imm         <= e_imm[iss_idx];
          pc          <= e_pc[iss_idx];
          out_rob_pos <= e_rob[iss_idx];
        end
        busy <= busy_left;
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            e_v1[i] <= fwd_v1[i];
            e_d1[i] <= fwd_d1[i];
            e_v2[i] <= fwd_v2[i];
            e_d2[i] <= fwd_d2[i];
          end
        end
        if (dispatch_en && free_found) begin
          busy[free_idx]   <= 1'b1;
          e_type[free_idx] <= dispatch_type;
          e_v1[free_idx]   <= cap_v1;
          e_d1[free_idx]   <= cap_d1;
          e_t1[free_idx]   <= dispatch_tag1;
          e_v2[free_idx]   <= cap_v2;
          e_d2[free_idx]   <= cap_d2;
          e_t2[free_idx]   <= dispatch_tag2;
          e_imm[free_idx]  <= dispatch_imm;
          e_pc[free_idx]   <= dispatch_pc;
          e_rob[free_idx]  <= dispatch_rob_pos;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station against a rule-level model
// Honours RS_FAST_WAKEUP_EN so the model matches whichever build is compiled.
module tb_reservation_station;
  localparam int N = 8;
`ifdef RS_FAST_WAKEUP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, dispatch_en;
  logic [5:0]  dispatch_type;
  logic [31:0] dispatch_val1, dispatch_val2, dispatch_imm, dispatch_pc;
  logic        dispatch_dep1, dispatch_dep2;
  logic [4:0]  dispatch_tag1, dispatch_tag2, dispatch_rob_pos;
  logic        rs_full;
  logic        alu_done, lsb_done;
  logic [31:0] alu_res, lsb_res;
  logic [4:0]  alu_rob_pos, lsb_rob_pos;
  logic        alu_todo;
  logic [5:0]  inst_type;
  logic [31:0] val1, val2, imm, pc;
  logic [4:0]  out_rob_pos;

  reservation_station #(.RS_SIZE(8), .RS_IDX_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .dispatch_en(dispatch_en), .dispatch_type(dispatch_type),
    .dispatch_val1(dispatch_val1), .dispatch_val2(dispatch_val2),
    .dispatch_dep1(dispatch_dep1), .dispatch_dep2(dispatch_dep2),
    .dispatch_tag1(dispatch_tag1), .dispatch_tag2(dispatch_tag2),
    .dispatch_imm(dispatch_imm), .dispatch_pc(dispatch_pc), .dispatch_rob_pos(dispatch_rob_pos),
    .rs_full(rs_full),
    .alu_done(alu_done), .alu_res(alu_res), .alu_rob_pos(alu_rob_pos),
    .lsb_done(lsb_done), .lsb_res(lsb_res), .lsb_rob_pos(lsb_rob_pos),
    .alu_todo(alu_todo), .inst_type(inst_type), .val1(val1), .val2(val2),
    .imm(imm), .pc(pc), .out_rob_pos(out_rob_pos)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit busy; bit [5:0] typ; bit [31:0] v1, v2; bit d1, d2;
    bit [4:0] t1, t2; bit [31:0] imm, pc; bit [4:0] rob;
  } ent_t;
  typedef struct {
    int cyc; bit [5:0] typ; bit [31:0] v1, v2, imm, pc; bit [4:0] rob;
  } iss_t;

  ent_t m[N];
  iss_t exp_q[$];
  iss_t last_out;
  bit   last_todo;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   full_chk_en = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit hit(input bit [4:0] t);
    return (alu_done && t == alu_rob_pos) || (lsb_done && t == lsb_rob_pos);
  endfunction

  // An operand counts as available for this edge only if already held, or (fast build) arriving now.
  function automatic bit known(input bit d, input bit [4:0] t);
    return !d || (FAST && hit(t));
  endfunction

  function automatic bit [31:0] opval(input bit d, input bit [4:0] t, input bit [31:0] v);
    if (d && alu_done && t == alu_rob_pos) return alu_res;
    if (d && lsb_done && t == lsb_rob_pos) return lsb_res;
    return v;
  endfunction

  function automatic bit model_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Applies the rules for the coming edge to the model and queues any expected issue.
  task automatic model_step();
    int iss;
    iss = -1;
    if (rst_in) begin
      foreach (m[i]) m[i].busy = 1'b0;
      last_todo = 1'b0;
      last_out = '{default: 0};
      return;
    end
    if (!rdy_in) return;
    if (rob_clear) begin
      foreach (m[i]) m[i].busy = 1'b0;
      last_todo = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && known(m[i].d1, m[i].t1) && known(m[i].d2, m[i].t2)) begin
        iss = i;
        break;
      end
    end
    last_todo = (iss >= 0);
    if (iss >= 0) begin
      iss_t e;
      e.cyc = cyc + 1;
      e.typ = m[iss].typ;
      e.v1  = opval(m[iss].d1, m[iss].t1, m[iss].v1);
      e.v2  = opval(m[iss].d2, m[iss].t2, m[iss].v2);
      e.imm = m[iss].imm;
      e.pc  = m[iss].pc;
      e.rob = m[iss].rob;
      exp_q.push_back(e);
      last_out = e;
      m[iss].busy = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy) begin
        m[i].v1 = opval(m[i].d1, m[i].t1, m[i].v1);
        m[i].d1 = m[i].d1 && !hit(m[i].t1);
        m[i].v2 = opval(m[i].d2, m[i].t2, m[i].v2);
        m[i].d2 = m[i].d2 && !hit(m[i].t2);
      end
    end
    if (dispatch_en) begin
      for (int i = 0; i < N; i++) begin
        if (!m[i].busy) begin
          m[i].busy = 1'b1;
          m[i].typ = dispatch_type;
          m[i].v1 = opval(dispatch_dep1, dispatch_tag1, dispatch_val1);
          m[i].d1 = dispatch_dep1 && !hit(dispatch_tag1);
          m[i].t1 = dispatch_tag1;
          m[i].v2 = opval(dispatch_dep2, dispatch_tag2, dispatch_val2);
          m[i].d2 = dispatch_dep2 && !hit(dispatch_tag2);
          m[i].t2 = dispatch_tag2;
          m[i].imm = dispatch_imm;
          m[i].pc = dispatch_pc;
          m[i].rob = dispatch_rob_pos;
          break;
        end
      end
    end
  endtask

  task automatic step();
    if (full_chk_en) chk("rs_full", 32'(rs_full), 32'(model_full()));
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    dispatch_en = 1'b0;
    alu_done = 1'b0;
    lsb_done = 1'b0;
    rob_clear = 1'b0;
    rst_in = 1'b0;
  endtask

  task automatic set_disp(input bit [5:0] ty, input bit [31:0] v1, input bit [31:0] v2,
                          input bit d1, input bit d2, input bit [4:0] t1, input bit [4:0] t2,
                          input bit [31:0] im, input bit [31:0] p, input bit [4:0] rob);
    dispatch_en = 1'b1;
    dispatch_type = ty;
    dispatch_val1 = v1;
    dispatch_val2 = v2;
    dispatch_dep1 = d1;
    dispatch_dep2 = d2;
    dispatch_tag1 = t1;
    dispatch_tag2 = t2;
    dispatch_imm = im;
    dispatch_pc = p;
    dispatch_rob_pos = rob;
  endtask

  // Monitor: pops the scoreboard on every issue; on frozen edges the outputs must hold.
  initial begin
    bit en;
    iss_t e;
    forever begin
      @(posedge clk_in);
      en = rdy_in || rst_in;
      #1;
      if (!en) begin
        chk("hold_todo", 32'(alu_todo), 32'(last_todo));
        chk("hold_val1", val1, last_out.v1);
        chk("hold_rob", 32'(out_rob_pos), 32'(last_out.rob));
      end else if (alu_todo) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue_rob", 32'(out_rob_pos), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("iss_cycle", 32'(cyc), 32'(e.cyc));
          chk("iss_type", 32'(inst_type), 32'(e.typ));
          chk("iss_val1", val1, e.v1);
          chk("iss_val2", val2, e.v2);
          chk("iss_imm", imm, e.imm);
          chk("iss_pc", pc, e.pc);
          chk("iss_rob", 32'(out_rob_pos), 32'(e.rob));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_issue_todo", 32'(alu_todo), 32'd1);
      end
    end
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; dispatch_en = 1'b0;
    dispatch_type = '0; dispatch_val1 = '0; dispatch_val2 = '0; dispatch_dep1 = 1'b0;
    dispatch_dep2 = 1'b0; dispatch_tag1 = '0; dispatch_tag2 = '0; dispatch_imm = '0;
    dispatch_pc = '0; dispatch_rob_pos = '0;
    alu_done = 1'b0; alu_res = '0; alu_rob_pos = '0;
    lsb_done = 1'b0; lsb_res = '0; lsb_rob_pos = '0;
    step();
    step();
    chk("reset_todo", 32'(alu_todo), 32'd0);
    chk("reset_type", 32'(inst_type), 32'd0);
    chk("reset_val1", val1, 32'd0);
    chk("reset_val2", val2, 32'd0);
    chk("reset_imm", imm, 32'd0);
    chk("reset_pc", pc, 32'd0);
    chk("reset_rob", 32'(out_rob_pos), 32'd0);
    chk("reset_full", 32'(rs_full), 32'd0);
    full_chk_en = 1'b1;

    // single ADDI with no dependencies
    set_disp(6'd18, 32'd5, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd7, 32'h100, 5'd3);
    step(); step(); step();

    // ADD waits on tag 4, then wakes from the ALU broadcast
    set_disp(6'd27, 32'd0, 32'd10, 1'b1, 1'b0, 5'd4, 5'd0, 32'd0, 32'h104, 5'd5);
    step();
    repeat (3) step();
    alu_done = 1'b1; alu_rob_pos = 5'd4; alu_res = 32'h20;
    step(); step(); step();

    // fill all entries on tag 9, drop a ninth, then release them in index order
    for (int i = 0; i < N; i++) begin
      set_disp(6'd20, 32'd0, 32'(i), 1'b1, 1'b0, 5'd9, 5'd0, 32'(i), 32'h200 + 32'(4 * i), 5'(10 + i));
      step();
    end
    chk("full_after_fill", 32'(rs_full), 32'd1);
    set_disp(6'd21, 32'd1, 32'd1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd99, 32'h300, 5'd20);
    step();
    lsb_done = 1'b1; lsb_rob_pos = 5'd9; lsb_res = 32'd1;
    step();
    repeat (10) step();

    // capture at dispatch from the LSB broadcast
    lsb_done = 1'b1; lsb_rob_pos = 5'd2; lsb_res = 32'hAB;
    set_disp(6'd22, 32'd0, 32'd3, 1'b1, 1'b0, 5'd2, 5'd0, 32'd1, 32'h400, 5'd8);
    step(); step(); step();

    // flush with three busy entries while one is about to issue
    set_disp(6'd23, 32'd0, 32'd0, 1'b1, 1'b0, 5'd11, 5'd0, 32'd0, 32'h500, 5'd1);
    step();
    set_disp(6'd24, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd12, 32'd0, 32'h504, 5'd2);
    step();
    set_disp(6'd25, 32'd4, 32'd4, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'h508, 5'd6);
    step();
    rob_clear = 1'b1;
    step();
    chk("flush_todo", 32'(alu_todo), 32'd0);
    chk("flush_full", 32'(rs_full), 32'd0);
    alu_done = 1'b1; alu_rob_pos = 5'd11; alu_res = 32'h77;
    lsb_done = 1'b1; lsb_rob_pos = 5'd12; lsb_res = 32'h88;
    step();
    repeat (3) step();

    // freeze with a ready entry present
    set_disp(6'd18, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd2, 32'h600, 5'd7);
    step();
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) set_disp(6'd19, 32'd9, 32'd9, 1'b0, 1'b0, 5'd0, 5'd0, 32'd9, 32'h700, 5'd9);
      step();
    end
    rdy_in = 1'b1;
    step(); step(); step();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      rdy_in = ($urandom_range(15) != 0);
      rob_clear = ($urandom_range(60) == 0);
      if (!model_full() && $urandom_range(1) == 1)
        set_disp(6'($urandom_range(36)), $urandom, $urandom, 1'($urandom_range(1)),
                 1'($urandom_range(1)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                 $urandom, $urandom, 5'($urandom_range(31)));
      alu_done = ($urandom_range(2) == 0);
      alu_rob_pos = 5'($urandom_range(7));
      alu_res = $urandom;
      lsb_done = ($urandom_range(2) == 0);
      lsb_rob_pos = 5'($urandom_range(7));
      lsb_res = $urandom;
      if (alu_done && lsb_done && alu_rob_pos == lsb_rob_pos) lsb_done = 1'b0;
      step();
    end
    rdy_in = 1'b1;
    rob_clear = 1'b1;
    step();
    repeat (12) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
